// File: rtl/rect_draw_pkg.sv
// Shared definitions for the rectangle rasteriser: draw modes, FSM states and
// default screen geometry.
package rect_draw_pkg;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  localparam int DEF_X_W      = 9;
  localparam int DEF_Y_W      = 8;
  localparam int DEF_COLOR_W  = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/rect_draw_engine_if.sv
// Command and pixel-port bundle between the game logic, the rasteriser and the
// VGA adapter. master = command issuer / pixel sink, slave = the rasteriser.
interface rect_draw_engine_if #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3
);
  logic               start;
  logic               abort;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [X_W-1:0]     w;
  logic [Y_W-1:0]     h;
  logic [COLOR_W-1:0] color_in;
  logic               mode;
  logic               plot_ready;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color;
  logic               plot;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, x0, y0, w, h, color_in, mode, plot_ready,
    input  x, y, color, plot, busy, done
  );

  modport slave (
    input  start, abort, x0, y0, w, h, color_in, mode, plot_ready,
    output x, y, color, plot, busy, done
  );
endinterface

// File: rtl/rect_clip.sv
// Clips a requested rectangle to the screen: exclusive end coordinates, an
// empty flag, and a thin flag (clipped width or height <= 2, outline == fill).
module rect_clip #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W:0]   xe,
  output logic [Y_W:0]   ye,
  output logic           empty,
  output logic           thin
);
  localparam logic [X_W:0] SCR_X = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_Y = (Y_W+1)'(SCREEN_H);

  logic [X_W:0] sum_x_s;
  logic [Y_W:0] sum_y_s;

  // One extra bit on the end sums so x0+w / y0+h never wrap before clipping.
  always_comb begin
    sum_x_s = {1'b0, x0} + {1'b0, w};
    sum_y_s = {1'b0, y0} + {1'b0, h};
    if (sum_x_s < SCR_X) begin
      xe = sum_x_s;
    end else begin
      xe = SCR_X;
    end
    if (sum_y_s < SCR_Y) begin
      ye = sum_y_s;
    end else begin
      ye = SCR_Y;
    end
    empty = (w == {X_W{1'b0}}) || (h == {Y_W{1'b0}}) ||
            ({1'b0, x0} >= SCR_X) || ({1'b0, y0} >= SCR_Y);
    thin  = ((xe - {1'b0, x0}) <= (X_W+1)'(2'd2)) ||
            ((ye - {1'b0, y0}) <= (Y_W+1)'(2'd2));
  end

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: scans a clipped fill or 1-pixel outline rectangle in
// raster order onto a pixel port with a per-pixel ready handshake.
module rect_draw_engine
  import rect_draw_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input logic               clk,
  input logic               rst,
  rect_draw_engine_if.slave bus
);

  logic [X_W:0] xe_s;
  logic [Y_W:0] ye_s;
  logic         empty_s;
  logic         thin_s;

  rect_clip #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .x0    (bus.x0),
    .y0    (bus.y0),
    .w     (bus.w),
    .h     (bus.h),
    .xe    (xe_s),
    .ye    (ye_s),
    .empty (empty_s),
    .thin  (thin_s)
  );

  state_t             state_r;
  logic [X_W-1:0]     x_r;
  logic [Y_W-1:0]     y_r;
  logic [X_W-1:0]     x0_r;
  logic [Y_W-1:0]     y0_r;
  logic [X_W:0]       xe_r;
  logic [Y_W:0]       ye_r;
  logic               hollow_r;
  logic [COLOR_W-1:0] color_r;
  logic               plot_r;
  logic               busy_r;
  logic               done_r;

  logic               last_col_s;
  logic               last_row_s;
  logic               side_row_s;
  logic [X_W-1:0]     x_next_s;

  // Next-pixel selection; interior outline rows jump straight from x0 to xe-1.
  always_comb begin
    last_col_s = ({1'b0, x_r} + (X_W+1)'(1'b1)) == xe_r;
    last_row_s = ({1'b0, y_r} + (Y_W+1)'(1'b1)) == ye_r;
    side_row_s = hollow_r && (y_r != y0_r) && !last_row_s;
    x_next_s   = x_r + X_W'(1'b1);
    if (side_row_s && (x_r == x0_r)) begin
      x_next_s = X_W'(xe_r - (X_W+1)'(1'b1));
    end else begin
      x_next_s = x_r + X_W'(1'b1);
    end
  end

  // Command acceptance, scan counters and registered pixel-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      x_r      <= {X_W{1'b0}};
      y_r      <= {Y_W{1'b0}};
      x0_r     <= {X_W{1'b0}};
      y0_r     <= {Y_W{1'b0}};
      xe_r     <= {(X_W+1){1'b0}};
      ye_r     <= {(Y_W+1){1'b0}};
      hollow_r <= 1'b0;
      color_r  <= {COLOR_W{1'b0}};
      plot_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            x0_r     <= bus.x0;
            y0_r     <= bus.y0;
            xe_r     <= xe_s;
            ye_r     <= ye_s;
            color_r  <= bus.color_in;
            hollow_r <= (bus.mode == MODE_OUTLINE) && !thin_s;
            if (empty_s) begin
              done_r <= 1'b1;
            end else begin
              state_r <= DRAW;
              busy_r  <= 1'b1;
              plot_r  <= 1'b1;
              x_r     <= bus.x0;
              y_r     <= bus.y0;
            end
          end
        end
        DRAW: begin
          if (bus.abort) begin
            state_r <= IDLE;
            plot_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else if (plot_r && bus.plot_ready) begin
            if (last_col_s) begin
              if (last_row_s) begin
                state_r <= IDLE;
                plot_r  <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                x_r <= x0_r;
                y_r <= y_r + Y_W'(1'b1);
              end
            end else begin
              x_r <= x_next_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          plot_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x     = x_r;
  assign bus.y     = y_r;
  assign bus.color = color_r;
  assign bus.plot  = plot_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule
